// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one KeyExpansion round per clock into an
// 11-entry round-key bank with a registered read port. Optional macro: KS_STREAM_EN.
module aes_key_schedule #(
  parameter int NR = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  key_in,
  output logic          busy,
  output logic          done,
  output logic          keys_ready,
  input  logic [AW-1:0] rk_idx,
  output logic [127:0]  rk_data
`ifdef KS_STREAM_EN
  ,
  output logic          rk_valid,
  output logic [127:0]  rk_stream
`endif
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, temp, n0, n1, n2, n3;
    rot  = {k[23:0], k[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rc, 24'h0};
    n0   = k[127:96] ^ temp;
    n1   = k[95:64]  ^ n0;
    n2   = k[63:32]  ^ n1;
    n3   = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t        state, state_next;
  logic [AW-1:0] rnd;
  logic [AW-1:0] prev_idx;
  logic [7:0]    rc;
  logic [127:0]  bank [NR+1];
  logic [127:0]  expanded;

  assign prev_idx = (rnd == '0) ? '0 : rnd - AW'(1);
  assign expanded = key_expand(bank[prev_idx], rc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (int'(rnd) == NR) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the bank is a flop array, not RAM, so it can and must clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rnd        <= '0;
      rc         <= 8'h01;
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bank[0]    <= key_in;
          rnd        <= AW'(1);
          rc         <= 8'h01;
          keys_ready <= 1'b0;
          busy       <= 1'b1;
        end
        EXPAND: begin
          bank[rnd] <= expanded;
          rc        <= xtime(rc);
          rnd       <= rnd + AW'(1);
        end
        FINISH: begin
          done       <= 1'b1;
          keys_ready <= 1'b1;
          busy       <= 1'b0;
          rnd        <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read port runs in every state; indices past the last round key read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rk_data <= '0;
    else if (int'(rk_idx) <= NR) rk_data <= bank[rk_idx];
    else                        rk_data <= '0;
  end

`ifdef KS_STREAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid  <= 1'b0;
      rk_stream <= '0;
    end else begin
      rk_valid <= 1'b0;
      if (state == IDLE && start) begin
        rk_valid  <= 1'b1;
        rk_stream <= key_in;
      end else if (state == EXPAND) begin
        rk_valid  <= 1'b1;
        rk_stream <= expanded;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key vectors.
// Stream checks compile in when KS_STREAM_EN is defined.
module tb_aes_key_schedule;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_RK10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10= 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
`ifdef KS_STREAM_EN
  logic         rk_valid;
  logic [127:0] rk_stream;
`endif

  int vectors     = 0;
  int miscompares = 0;

  aes_key_schedule #(.NR(10), .AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_ready (keys_ready),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data)
`ifdef KS_STREAM_EN
    ,
    .rk_valid   (rk_valid),
    .rk_stream  (rk_stream)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sets rk_idx on a falling edge and returns the registered data one cycle later.
  task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
    @(negedge clk) rk_idx = idx;
    @(negedge clk) data = rk_data;
  endtask

  // Pulses start with key and reports the falling-edge count at which done was seen
  // (0 if never within the budget) and how many cycles done was high.
  task automatic run_key(input logic [127:0] key, output int done_cycle, output int done_count);
    done_cycle = 0;
    done_count = 0;
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
    end
  endtask

  task automatic test_reset;
    logic [127:0] d;
    rst_n  = 1'b0;
    start  = 1'b1;
    key_in = K1;
    rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, keys_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: busy/done/keys_ready=%b expected 000", {busy, done, keys_ready});
    end
    vectors++;
    if (rk_data !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_rk_data: got %h expected 0", rk_data);
    end
    start = 1'b0;
    rst_n = 1'b1;
    read_rk(4'd0, d);
    vectors++;
    if (d !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_bank0: got %h expected 0", d);
    end
  endtask

  task automatic test_fips;
    int dc, dn;
    logic [127:0] d;
    run_key(K1, dc, dn);
    vectors++;
    if (dc !== 12) begin
      miscompares++;
      $display("FAIL fips_done_latency: done at cycle %0d expected 12", dc);
    end
    vectors++;
    if (dn !== 1) begin
      miscompares++;
      $display("FAIL fips_done_width: done high %0d cycles expected 1", dn);
    end
    vectors++;
    if ({busy, keys_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL fips_status: busy/keys_ready=%b expected 01", {busy, keys_ready});
    end
    read_rk(4'd1, d);
    vectors++;
    if (d !== K1_RK1) begin
      miscompares++;
      $display("FAIL fips_rk1: got %h expected %h", d, K1_RK1);
    end
    read_rk(4'd2, d);
    vectors++;
    if (d !== K1_RK2) begin
      miscompares++;
      $display("FAIL fips_rk2: got %h expected %h", d, K1_RK2);
    end
    read_rk(4'd10, d);
    vectors++;
    if (d !== K1_RK10) begin
      miscompares++;
      $display("FAIL fips_rk10: got %h expected %h", d, K1_RK10);
    end
  endtask

  task automatic test_out_of_range;
    logic [127:0] d;
    read_rk(4'd15, d);
    vectors++;
    if (d !== 128'h0) begin
      miscompares++;
      $display("FAIL oor_rk15: got %h expected 0", d);
    end
    read_rk(4'd11, d);
    vectors++;
    if (d !== 128'h0) begin
      miscompares++;
      $display("FAIL oor_rk11: got %h expected 0", d);
    end
    read_rk(4'd0, d);
    vectors++;
    if (d !== K1) begin
      miscompares++;
      $display("FAIL oor_rk0: got %h expected %h", d, K1);
    end
  endtask

  task automatic test_restart_ignored;
    int dc = 0, dn = 0;
    logic [127:0] d;
    @(negedge clk);
    key_in = K1;
    start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        key_in = K2;
        start  = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (done) begin
        dn++;
        if (dc == 0) dc = c;
      end
    end
    vectors++;
    if (dc !== 12 || dn !== 1) begin
      miscompares++;
      $display("FAIL restart_done: done at %0d (%0d cycles) expected 12 (1)", dc, dn);
    end
    read_rk(4'd0, d);
    vectors++;
    if (d !== K1) begin
      miscompares++;
      $display("FAIL restart_rk0: got %h expected %h", d, K1);
    end
    read_rk(4'd10, d);
    vectors++;
    if (d !== K1_RK10) begin
      miscompares++;
      $display("FAIL restart_rk10: got %h expected %h", d, K1_RK10);
    end
  endtask

  task automatic test_reset_mid;
    int dc, dn, seen = 0;
    logic [127:0] d;
    @(negedge clk);
    key_in = K1;
    start  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, keys_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_flags: busy/done/keys_ready=%b expected 000", {busy, done, keys_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done || keys_ready || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: status active on %0d cycles expected 0", seen);
    end
    run_key(K2, dc, dn);
    vectors++;
    if (dc !== 12) begin
      miscompares++;
      $display("FAIL midreset_done: done at cycle %0d expected 12", dc);
    end
    read_rk(4'd1, d);
    vectors++;
    if (d !== K2_RK1) begin
      miscompares++;
      $display("FAIL midreset_rk1: got %h expected %h", d, K2_RK1);
    end
    read_rk(4'd10, d);
    vectors++;
    if (d !== K2_RK10) begin
      miscompares++;
      $display("FAIL midreset_rk10: got %h expected %h", d, K2_RK10);
    end
  endtask

  task automatic test_back_to_back;
    int dc = 0;
    logic [127:0] d;
    @(negedge clk);
    key_in = K1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, keys_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_accept: busy/keys_ready=%b expected 10", {busy, keys_ready});
    end
    for (int c = 2; c <= 20 && dc == 0; c++) begin
      @(negedge clk);
      if (done) dc = c;
    end
    vectors++;
    if (dc !== 12) begin
      miscompares++;
      $display("FAIL b2b_done: done at cycle %0d expected 12", dc);
    end
    read_rk(4'd2, d);
    vectors++;
    if (d !== K1_RK2) begin
      miscompares++;
      $display("FAIL b2b_rk2: got %h expected %h", d, K1_RK2);
    end
  endtask

`ifdef KS_STREAM_EN
  task automatic test_stream;
    int pulses = 0;
    logic [127:0] second = '0;
    @(negedge clk);
    key_in = K1;
    start  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (rk_valid) begin
        pulses++;
        if (pulses == 2) second = rk_stream;
      end
    end
    vectors++;
    if (pulses !== 11) begin
      miscompares++;
      $display("FAIL stream_count: %0d pulses expected 11", pulses);
    end
    vectors++;
    if (second !== K1_RK1) begin
      miscompares++;
      $display("FAIL stream_second: got %h expected %h", second, K1_RK1);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fips;
    test_out_of_range;
    test_restart_ignored;
    test_reset_mid;
    test_back_to_back;
`ifdef KS_STREAM_EN
    test_stream;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
